// File: rtl/rtc_tick_gen.sv
// Multi-channel programmable clock divider: each channel emits a divided clock
// and a one-cycle tick at every divided-clock rising edge.
module rtc_tick_gen #(
    parameter int NumCh      = 2,
    parameter int CntWidth   = 16,
    parameter int DefaultDiv = 50
) (
    input  logic                      soc_clk,
    input  logic                      rst_n,
    input  logic [NumCh-1:0]          en_i,
    input  logic [NumCh*CntWidth-1:0] div_i,
    input  logic [NumCh-1:0]          div_valid_i,
    output logic [NumCh-1:0]          div_ready_o,
    output logic [NumCh-1:0]          clk_o,
    output logic [NumCh-1:0]          tick_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_e;

    localparam logic [CntWidth-1:0] DefDiv = CntWidth'(DefaultDiv);
    localparam logic [CntWidth-1:0] One    = CntWidth'(1);
    localparam logic [CntWidth-1:0] Two    = CntWidth'(2);

    // Divisors of 0 and 1 behave as 2.
    function automatic logic [CntWidth-1:0] eff_div(input logic [CntWidth-1:0] d);
        return (d < Two) ? Two : d;
    endfunction

    function automatic logic [CntWidth-1:0] high_time(input logic [CntWidth-1:0] d);
        logic [CntWidth-1:0] e;
        e = eff_div(d);
        return e - (e >> 1);
    endfunction

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        state_e              state_q, state_d;
        logic [CntWidth-1:0] cnt_q, cnt_d;
        logic [CntWidth-1:0] div_q, div_d;
        logic [CntWidth-1:0] stg_q, stg_d;
        logic                staged_q, staged_d;
        logic                clk_q, clk_d;
        logic                tick_q, tick_d;
        logic [CntWidth-1:0] cnt_adv;
        logic                wrap;

        always_ff @(posedge soc_clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                div_q    <= DefDiv;
                stg_q    <= '0;
                staged_q <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                div_q    <= div_d;
                stg_q    <= stg_d;
                staged_q <= staged_d;
                clk_q    <= clk_d;
                tick_q   <= tick_d;
            end
        end

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            div_d    = div_q;
            stg_d    = stg_q;
            staged_d = staged_q;
            wrap     = (state_q != IDLE) && (cnt_q == eff_div(div_q) - One);
            cnt_adv  = wrap ? '0 : cnt_q + One;

            // Staged divisor only lands between periods, so a period never mixes divisors.
            if (staged_q && (state_q == IDLE || wrap)) begin
                div_d    = stg_q;
                staged_d = 1'b0;
            end
            if (div_valid_i[c] && !staged_q) begin
                stg_d    = div_i[c*CntWidth +: CntWidth];
                staged_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (en_i[c]) state_d = RUN;
                end
                RUN: begin
                    cnt_d = cnt_adv;
                    if (!en_i[c]) state_d = STOP;
                end
                STOP: begin
                    cnt_d = cnt_adv;
                    if (en_i[c])   state_d = RUN;
                    else if (wrap) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase

            // Outputs are registered from next-state values so they align with cnt_q.
            clk_d  = (state_d != IDLE) && (cnt_d < high_time(div_d));
            tick_d = (state_d != IDLE) && (cnt_d == '0);
        end

        assign clk_o[c]       = clk_q;
        assign tick_o[c]      = tick_q;
        assign div_ready_o[c] = ~staged_q;
    end

endmodule

// File: tb/tb_rtc_tick_gen.sv
// Self-checking bench for rtc_tick_gen: directed scenarios plus randomized
// traffic, compared each cycle against a period-position reference model.
module tb_rtc_tick_gen;
    localparam int NCH = 4;
    localparam int W   = 16;

    logic             soc_clk = 1'b0;
    logic             rst_n   = 1'b0;
    logic [NCH-1:0]   en      = '0;
    logic [NCH*W-1:0] div_v   = '0;
    logic [NCH-1:0]   dv      = '0;
    logic [NCH-1:0]   ready_o, clk_o, tick_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: position within the current period plus activity flags.
    bit m_act[NCH];
    bit m_stop[NCH];
    bit m_pend[NCH];
    int m_pos[NCH];
    int m_div[NCH];
    int m_sv[NCH];

    rtc_tick_gen #(.NumCh(NCH), .CntWidth(W), .DefaultDiv(50)) dut (
        .soc_clk    (soc_clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .div_i      (div_v),
        .div_valid_i(dv),
        .div_ready_o(ready_o),
        .clk_o      (clk_o),
        .tick_o     (tick_o)
    );

    always #5 soc_clk = ~soc_clk;

    function automatic int eff(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic check(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_act[c] = 0; m_stop[c] = 0; m_pend[c] = 0;
            m_pos[c] = 0; m_div[c] = 50; m_sv[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            int  e;
            bit  at_end;
            e      = eff(m_div[c]);
            at_end = m_act[c] && (m_pos[c] == e - 1);
            if (m_pend[c] && (!m_act[c] || at_end)) begin
                m_div[c]  = m_sv[c];
                m_pend[c] = 0;
            end else if (dv[c] && !m_pend[c]) begin
                m_sv[c]   = int'(div_v[c*W +: W]);
                m_pend[c] = 1;
            end
            if (!m_act[c]) begin
                if (en[c]) begin m_act[c] = 1; m_stop[c] = 0; m_pos[c] = 0; end
            end else begin
                m_pos[c] = at_end ? 0 : m_pos[c] + 1;
                if (en[c])       m_stop[c] = 0;
                else if (!m_stop[c]) m_stop[c] = 1;
                else if (at_end) m_act[c] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0] e_clk, e_tick, e_rdy;
        for (int c = 0; c < NCH; c++) begin
            int e;
            e         = eff(m_div[c]);
            e_clk[c]  = m_act[c] && (m_pos[c] < e - e / 2);
            e_tick[c] = m_act[c] && (m_pos[c] == 0);
            e_rdy[c]  = !m_pend[c];
        end
        check("clk_o", clk_o, e_clk);
        check("tick_o", tick_o, e_tick);
        check("div_ready_o", ready_o, e_rdy);
    endtask

    task automatic cycle();
        if (rst_n) model_step();
        @(posedge soc_clk);
        @(negedge soc_clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_pos(input int c, input int p);
        bit found;
        found = 0;
        for (int i = 0; i < 70000 && !found; i++) begin
            if (m_act[c] && m_pos[c] == p) found = 1;
            else cycle();
        end
        check("wait_pos_timeout", {3'b0, found}, 4'b0001);
    endtask

    task automatic write_div(input int c, input int val);
        div_v[c*W +: W] = W'(val);
        dv[c] = 1'b1;
        cycle();
        dv[c] = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_clk_o", clk_o, '0);
        check("rst_tick_o", tick_o, '0);
        check("rst_ready_o", ready_o, '1);
        model_reset();
        @(negedge soc_clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge soc_clk);
        check("reset_clk_o", clk_o, '0);
        check("reset_tick_o", tick_o, '0);
        check("reset_ready_o", ready_o, '1);
        rst_n = 1'b1;
        run(3);

        // Default divisor, ten periods; first tick one cycle after enable.
        en[0] = 1'b1;
        cycle();
        check("first_tick", {3'b0, tick_o[0]}, 4'b0001);
        run(499);

        // Divisor update mid-period: current period completes with 50.
        wait_pos(0, 10);
        write_div(0, 7);
        check("ready_low_after_accept", {3'b0, ready_o[0]}, 4'b0000);
        run(80);

        // Degenerate and odd divisors.
        write_div(0, 0);
        run(20);
        write_div(0, 1);
        run(20);
        write_div(0, 3);
        run(20);
        write_div(0, 50);
        run(60);

        // Disable/re-enable within a period, then full stop to idle.
        wait_pos(0, 5);
        en[0] = 1'b0;
        wait_pos(0, 30);
        en[0] = 1'b1;
        run(40);
        wait_pos(0, 5);
        en[0] = 1'b0;
        run(60);
        check("stopped_idle", {3'b0, clk_o[0]}, 4'b0000);

        // Reset mid-high phase with an update staged: divisor returns to 50.
        en[0] = 1'b1;
        wait_pos(0, 3);
        write_div(0, 7);
        wait_pos(0, 12);
        check("pre_reset_high", {3'b0, clk_o[0]}, 4'b0001);
        do_reset();
        run(110);

        // Reset with 7 active, then run at the default divisor again.
        write_div(0, 7);
        run(60);
        do_reset();
        run(60);

        // All channels simultaneously with distinct divisors.
        en = '0;
        run(60);
        div_v = {16'd65535, 16'd50, 16'd3, 16'd2};
        dv = '1;
        cycle();
        dv = '0;
        run(2);
        en = '1;
        run(300);
        div_v = {16'd9, 16'd7, 16'd6, 16'd5};
        dv = '1;
        cycle();
        dv = '0;
        run(200);

        // Randomized traffic on every channel.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                dv[c] = ($urandom_range(0, 15) == 0);
                div_v[c*W +: W] = W'($urandom_range(0, 12));
                if ($urandom_range(0, 149) == 0) en[c] = ~en[c];
            end
            cycle();
        end
        dv = '0;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
